// File: rtl/jesd204_pkg.sv
// Shared constants and types for the JESD204B single-lane receiver.
// Control characters, link state encoding and ILAS configuration size.
package jesd204_pkg;

   localparam logic [7:0] K_CHAR = 8'hBC;
   localparam logic [7:0] R_CHAR = 8'h1C;
   localparam logic [7:0] A_CHAR = 8'h7C;
   localparam logic [7:0] Q_CHAR = 8'h9C;
   localparam logic [7:0] F_CHAR = 8'hFC;

   localparam int ILAS_OCTETS = 14;

   typedef enum logic [1:0] {
      ST_CGS  = 2'd0,
      ST_ILAS = 2'd1,
      ST_DATA = 2'd2
   } link_state_t;

endpackage

// File: rtl/jesd204_rx_char_replace.sv
// DATA-state octet3 character replacement and per-word error flag.
// prev_oct holds the last delivered octet3 and is zero outside DATA.
module jesd204_rx_char_replace
   import jesd204_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        active,
   input  logic        last_word,
   input  logic [31:0] data_in,
   input  logic [3:0]  charisk,
   input  logic [3:0]  disperr,
   input  logic [3:0]  notintable,
   output logic [31:0] frame_out,
   output logic        word_err
);

   logic [7:0] prev_oct_reg;
   logic [7:0] oct3;
   logic       is_a;
   logic       is_f;
   logic       replace;

   assign oct3    = data_in[31:24];
   assign is_a    = charisk[3] && (oct3 == A_CHAR);
   assign is_f    = charisk[3] && (oct3 == F_CHAR);
   assign replace = last_word ? is_a : is_f;

   assign frame_out = {(replace ? prev_oct_reg : oct3), data_in[23:0]};

   // Any K on octet3 that is not the legal replacement character is an error.
   assign word_err = (|disperr) || (|notintable) || (|charisk[2:0])
                     || (charisk[3] && !replace);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_oct_reg <= 8'h00;
      end else if (!active) begin
         prev_oct_reg <= 8'h00;
      end else begin
         prev_oct_reg <= frame_out[31:24];
      end
   end

endmodule

// File: rtl/jesd204_rx_lane.sv
// Single-lane JESD204B link-layer receiver: CGS / ILAS / DATA state machine,
// SYNC~ handshake, ILAS config capture and error accounting.
module jesd204_rx_lane
   import jesd204_pkg::*;
#(
   parameter int K_FRAMES   = 32,
   parameter int CGS_K_MIN  = 4,
   parameter int SYNC_MIN   = 8,
   parameter int ERR_THRESH = 8
) (
   input  logic         clk_user_bufg,
   input  logic         rst_glb,
   input  logic         rst_sync,
   input  logic [31:0]  rx_data,
   input  logic [3:0]   rx_charisk,
   input  logic [3:0]   rx_disperr,
   input  logic [3:0]   rx_notintable,
   output logic         sync_n,
   output logic         rx_valid,
   output logic [31:0]  rx_frame,
   output logic [111:0] ilas_cfg,
   output logic         ilas_cfg_valid,
   output logic [1:0]   link_state,
   output logic [7:0]   err_cnt,
   output logic         link_err
);

   localparam logic [4:0] WC_LAST      = 5'(K_FRAMES - 1);
   localparam logic [7:0] K_MIN_L      = 8'(CGS_K_MIN);
   localparam logic [7:0] SYNC_MIN_L   = 8'(SYNC_MIN);
   localparam logic [7:0] ERR_THRESH_L = 8'(ERR_THRESH);

   link_state_t  state_reg, state_next;
   logic [4:0]   wc_reg, wc_next;
   logic [1:0]   mf_reg, mf_next;
   logic [7:0]   k_cnt_reg, k_cnt_next;
   logic [7:0]   sync_cnt_reg, sync_cnt_next;
   logic [7:0]   err_cnt_reg, err_cnt_next;
   logic         sync_n_reg, sync_n_next;
   logic         rx_valid_reg, rx_valid_next;
   logic         cfg_valid_reg, cfg_valid_next;
   logic         link_err_reg, link_err_next;
   logic [31:0]  rx_frame_reg, rx_frame_next;
   logic [111:0] ilas_cfg_reg;

   logic         word_clean, k_word, r_start, last_word, ilas_ok, go_cgs;
   logic [4:0]   wc_inc;
   logic [31:0]  data_frame;
   logic         data_err;
   logic         cfg_capture;
   logic [ILAS_OCTETS-1:0] cfg_en;
   logic [7:0]   cfg_src [ILAS_OCTETS];

   assign word_clean = !(|rx_disperr) && !(|rx_notintable);
   assign k_word     = word_clean && (rx_charisk == 4'hF) && (rx_data == {4{K_CHAR}});
   assign r_start    = word_clean && rx_charisk[0] && (rx_data[7:0] == R_CHAR);
   assign last_word  = (wc_reg == WC_LAST);
   assign wc_inc     = last_word ? 5'd0 : wc_reg + 5'd1;

   assign ilas_ok = word_clean
      && ((wc_reg != 5'd0) || (rx_charisk[0] && rx_data[7:0] == R_CHAR))
      && ((wc_reg != 5'd0) || (mf_reg != 2'd1) || (rx_charisk[1] && rx_data[15:8] == Q_CHAR))
      && (!last_word || (rx_charisk[3] && rx_data[31:24] == A_CHAR));

   jesd204_rx_char_replace u_char_replace (
      .clk        (clk_user_bufg),
      .rst        (rst_glb),
      .active     (state_reg == ST_DATA),
      .last_word  (last_word),
      .data_in    (rx_data),
      .charisk    (rx_charisk),
      .disperr    (rx_disperr),
      .notintable (rx_notintable),
      .frame_out  (data_frame),
      .word_err   (data_err)
   );

   always_comb begin
      state_next     = state_reg;
      wc_next        = wc_reg;
      mf_next        = mf_reg;
      k_cnt_next     = k_cnt_reg;
      sync_cnt_next  = sync_cnt_reg;
      err_cnt_next   = err_cnt_reg;
      sync_n_next    = sync_n_reg;
      rx_valid_next  = rx_valid_reg;
      rx_frame_next  = rx_frame_reg;
      cfg_valid_next = cfg_valid_reg;
      link_err_next  = 1'b0;
      go_cgs         = 1'b0;

      if (rst_sync) begin
         go_cgs = 1'b1;
      end else begin
         case (state_reg)
            ST_CGS: begin
               sync_cnt_next = (sync_cnt_reg == 8'hFF) ? sync_cnt_reg : sync_cnt_reg + 8'd1;
               if (sync_n_reg && r_start) begin
                  // The /R/ word itself is word 0 of multiframe 0.
                  state_next = ST_ILAS;
                  wc_next    = 5'd1;
                  mf_next    = 2'd0;
               end else if (k_word) begin
                  k_cnt_next = (k_cnt_reg == 8'hFF) ? k_cnt_reg : k_cnt_reg + 8'd1;
                  if (k_cnt_next >= K_MIN_L && sync_cnt_next >= SYNC_MIN_L) begin
                     sync_n_next = 1'b1;
                  end
               end else begin
                  k_cnt_next = 8'd0;
                  if (sync_n_reg) begin
                     sync_n_next   = 1'b0;
                     sync_cnt_next = 8'd0;
                  end
               end
            end
            ST_ILAS: begin
               if (!ilas_ok) begin
                  link_err_next = 1'b1;
                  go_cgs        = 1'b1;
               end else begin
                  wc_next = wc_inc;
                  if (last_word) begin
                     mf_next = mf_reg + 2'd1;
                     if (mf_reg == 2'd1) begin
                        cfg_valid_next = 1'b1;
                     end
                     if (mf_reg == 2'd3) begin
                        state_next   = ST_DATA;
                        err_cnt_next = 8'd0;
                     end
                  end
               end
            end
            ST_DATA: begin
               wc_next       = wc_inc;
               rx_valid_next = 1'b1;
               rx_frame_next = data_frame;
               if (data_err) begin
                  link_err_next = 1'b1;
                  err_cnt_next  = (err_cnt_reg == 8'hFF) ? err_cnt_reg : err_cnt_reg + 8'd1;
                  if (err_cnt_next >= ERR_THRESH_L) begin
                     go_cgs = 1'b1;
                  end
               end
            end
            default: go_cgs = 1'b1;
         endcase
      end

      if (go_cgs) begin
         state_next     = ST_CGS;
         sync_n_next    = 1'b0;
         rx_valid_next  = 1'b0;
         cfg_valid_next = 1'b0;
         k_cnt_next     = 8'd0;
         sync_cnt_next  = 8'd0;
         wc_next        = 5'd0;
         mf_next        = 2'd0;
      end
   end

   always_ff @(posedge clk_user_bufg or posedge rst_glb) begin
      if (rst_glb) begin
         state_reg     <= ST_CGS;
         wc_reg        <= 5'd0;
         mf_reg        <= 2'd0;
         k_cnt_reg     <= 8'd0;
         sync_cnt_reg  <= 8'd0;
         err_cnt_reg   <= 8'd0;
         sync_n_reg    <= 1'b0;
         rx_valid_reg  <= 1'b0;
         cfg_valid_reg <= 1'b0;
         link_err_reg  <= 1'b0;
         rx_frame_reg  <= 32'd0;
      end else begin
         state_reg     <= state_next;
         wc_reg        <= wc_next;
         mf_reg        <= mf_next;
         k_cnt_reg     <= k_cnt_next;
         sync_cnt_reg  <= sync_cnt_next;
         err_cnt_reg   <= err_cnt_next;
         sync_n_reg    <= sync_n_next;
         rx_valid_reg  <= rx_valid_next;
         cfg_valid_reg <= cfg_valid_next;
         link_err_reg  <= link_err_next;
         rx_frame_reg  <= rx_frame_next;
      end
   end

   // Config octets 0..1 come from mf1 word0 octets 2..3, the rest from words 1..3.
   assign cfg_capture = (state_reg == ST_ILAS) && (mf_reg == 2'd1) && word_clean && !rst_sync;

   generate
      for (genvar gi = 0; gi < ILAS_OCTETS; gi++) begin : g_cfg
         localparam int SRC_WC  = (gi < 2) ? 0 : ((gi - 2) / 4) + 1;
         localparam int SRC_OCT = (gi < 2) ? gi + 2 : (gi - 2) % 4;
         assign cfg_en[gi]  = cfg_capture && (wc_reg == 5'(SRC_WC));
         assign cfg_src[gi] = rx_data[SRC_OCT*8 +: 8];
      end
   endgenerate

   always_ff @(posedge clk_user_bufg or posedge rst_glb) begin
      if (rst_glb) begin
         ilas_cfg_reg <= '0;
      end else begin
         for (int i = 0; i < ILAS_OCTETS; i++) begin
            if (cfg_en[i]) begin
               ilas_cfg_reg[i*8 +: 8] <= cfg_src[i];
            end
         end
      end
   end

   assign sync_n         = sync_n_reg;
   assign rx_valid       = rx_valid_reg;
   assign rx_frame       = rx_frame_reg;
   assign ilas_cfg       = ilas_cfg_reg;
   assign ilas_cfg_valid = cfg_valid_reg;
   assign link_state     = state_reg;
   assign err_cnt        = err_cnt_reg;
   assign link_err       = link_err_reg;

endmodule

// File: tb/tb_jesd204_rx_lane.sv
// Directed bench for jesd204_rx_lane: sync handshake, ILAS capture, DATA
// replacement/error handling, resync priority and asynchronous reset.
module tb_jesd204_rx_lane;

   localparam int KF = 8;
   localparam logic [111:0] CFG_EXP = 112'h0E0D0C0B0A090807060504030201;

   logic         clk_user_bufg = 1'b0;
   logic         rst_glb;
   logic         rst_sync;
   logic [31:0]  rx_data;
   logic [3:0]   rx_charisk;
   logic [3:0]   rx_disperr;
   logic [3:0]   rx_notintable;
   logic         sync_n;
   logic         rx_valid;
   logic [31:0]  rx_frame;
   logic [111:0] ilas_cfg;
   logic         ilas_cfg_valid;
   logic [1:0]   link_state;
   logic [7:0]   err_cnt;
   logic         link_err;

   int n_checks = 0;
   int n_fail   = 0;

   jesd204_rx_lane #(
      .K_FRAMES   (KF),
      .CGS_K_MIN  (4),
      .SYNC_MIN   (8),
      .ERR_THRESH (2)
   ) dut (
      .clk_user_bufg  (clk_user_bufg),
      .rst_glb        (rst_glb),
      .rst_sync       (rst_sync),
      .rx_data        (rx_data),
      .rx_charisk     (rx_charisk),
      .rx_disperr     (rx_disperr),
      .rx_notintable  (rx_notintable),
      .sync_n         (sync_n),
      .rx_valid       (rx_valid),
      .rx_frame       (rx_frame),
      .ilas_cfg       (ilas_cfg),
      .ilas_cfg_valid (ilas_cfg_valid),
      .link_state     (link_state),
      .err_cnt        (err_cnt),
      .link_err       (link_err)
   );

   always #5 clk_user_bufg = ~clk_user_bufg;

   task automatic check_value(input string tag, input logic [111:0] got, input logic [111:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_word(input logic [31:0] d, input logic [3:0] k,
                            input logic [3:0] de, input logic rs);
      @(negedge clk_user_bufg);
      rx_data       = d;
      rx_charisk    = k;
      rx_disperr    = de;
      rx_notintable = 4'h0;
      rst_sync      = rs;
      @(posedge clk_user_bufg);
      #1;
      rst_sync = 1'b0;
      $display("word %08h k=%h de=%h rs=%0d -> sync_n=%0d st=%0d valid=%0d frame=%08h err_cnt=%0d link_err=%0d",
               d, k, de, rs, sync_n, link_state, rx_valid, rx_frame, err_cnt, link_err);
   endtask

   task automatic send_k(input int n);
      for (int i = 0; i < n; i++) send_word(32'hBCBCBCBC, 4'hF, 4'h0, 1'b0);
   endtask

   // Sends the ILAS sequence; break_mf >= 0 omits the /A/ ending that multiframe.
   task automatic send_ilas(input int break_mf);
      logic [7:0]  b [4];
      logic [3:0]  k;
      for (int mf = 0; mf < 4; mf++) begin
         for (int w = 0; w < KF; w++) begin
            b[0] = 8'h00; b[1] = 8'(w); b[2] = 8'(mf); b[3] = 8'h5A; k = 4'h0;
            if (w == 0) begin
               b[0] = 8'h1C; k[0] = 1'b1;
               if (mf == 1) begin
                  b[1] = 8'h9C; k[1] = 1'b1; b[2] = 8'h01; b[3] = 8'h02;
               end
            end
            if (mf == 1 && w >= 1 && w <= 3) begin
               for (int i = 0; i < 4; i++) b[i] = 8'(4*(w-1) + i + 3);
            end
            if (w == KF-1 && mf != break_mf) begin
               b[3] = 8'h7C; k[3] = 1'b1;
            end
            send_word({b[3], b[2], b[1], b[0]}, k, 4'h0, 1'b0);
            if (mf == 0 && w == 3) check_value("ilas_state", 112'(link_state), 112'd1);
            if (mf == 1 && w == KF-2) check_value("cfg_valid_early", 112'(ilas_cfg_valid), 112'd0);
            if (mf == 1 && w == KF-1) begin
               check_value("cfg_valid_mf1", 112'(ilas_cfg_valid), 112'd1);
               check_value("ilas_cfg", ilas_cfg, CFG_EXP);
            end
            if (mf == break_mf && w == KF-1) return;
         end
      end
   endtask

   initial begin
      rst_glb = 1'b1; rst_sync = 1'b0;
      rx_data = 32'd0; rx_charisk = 4'h0; rx_disperr = 4'h0; rx_notintable = 4'h0;
      repeat (3) @(posedge clk_user_bufg);
      #1;
      check_value("rst_sync_n", 112'(sync_n), 112'd0);
      check_value("rst_valid", 112'(rx_valid), 112'd0);
      check_value("rst_frame", 112'(rx_frame), 112'd0);
      check_value("rst_cfg", ilas_cfg, 112'd0);
      check_value("rst_state", 112'(link_state), 112'd0);
      check_value("rst_errcnt", 112'(err_cnt), 112'd0);
      @(negedge clk_user_bufg);
      rst_glb = 1'b0;

      // CGS: 3 /K/, a break word, then /K/ until both conditions meet at word 8.
      send_k(3);
      check_value("sync_after_3k", 112'(sync_n), 112'd0);
      send_word(32'h00000000, 4'h0, 4'h0, 1'b0);
      send_k(3);
      check_value("sync_word7", 112'(sync_n), 112'd0);
      send_k(1);
      check_value("sync_word8", 112'(sync_n), 112'd1);
      send_k(6);
      check_value("sync_hold", 112'(sync_n), 112'd1);

      // ILAS with missing /A/ at the end of mf 2.
      send_ilas(2);
      check_value("miss_a_err", 112'(link_err), 112'd1);
      check_value("miss_a_state", 112'(link_state), 112'd0);
      check_value("miss_a_sync", 112'(sync_n), 112'd0);
      check_value("miss_a_cfgv", 112'(ilas_cfg_valid), 112'd0);
      send_k(1);
      check_value("err_pulse_end", 112'(link_err), 112'd0);
      send_k(6);
      check_value("sync_min_hold", 112'(sync_n), 112'd0);
      send_k(1);
      check_value("resync_rise", 112'(sync_n), 112'd1);

      // Full ILAS then DATA.
      send_ilas(-1);
      check_value("data_entry_state", 112'(link_state), 112'd2);
      check_value("data_entry_valid", 112'(rx_valid), 112'd0);
      send_word(32'h11223344, 4'h0, 4'h0, 1'b0);
      check_value("first_valid", 112'(rx_valid), 112'd1);
      check_value("first_frame", 112'(rx_frame), 112'h11223344);
      send_word(32'h55AABBCC, 4'h0, 4'h0, 1'b0);
      send_word(32'hFC223344, 4'h8, 4'h0, 1'b0);
      check_value("f_replace", 112'(rx_frame), 112'h55223344);
      check_value("f_no_err", 112'(link_err), 112'd0);
      send_word(32'h7C000000, 4'h8, 4'h0, 1'b0);
      check_value("a_mid_err", 112'(link_err), 112'd1);
      check_value("a_mid_cnt", 112'(err_cnt), 112'd1);
      check_value("a_mid_state", 112'(link_state), 112'd2);
      send_word(32'h01020304, 4'h0, 4'h0, 1'b0);
      send_word(32'h00000000, 4'h0, 4'h0, 1'b0);
      send_word(32'h66000000, 4'h0, 4'h0, 1'b0);
      send_word(32'h7C0000AA, 4'h8, 4'h0, 1'b0);
      check_value("a_last_replace", 112'(rx_frame), 112'h660000AA);
      check_value("a_last_no_err", 112'(link_err), 112'd0);
      send_word(32'h12345678, 4'h0, 4'h1, 1'b0);
      check_value("thresh_cnt", 112'(err_cnt), 112'd2);
      check_value("thresh_state", 112'(link_state), 112'd0);
      check_value("thresh_sync", 112'(sync_n), 112'd0);
      check_value("thresh_valid", 112'(rx_valid), 112'd0);
      check_value("cfg_kept", ilas_cfg, CFG_EXP);
      check_value("cfgv_cleared", 112'(ilas_cfg_valid), 112'd0);

      // rst_sync coinciding with an error-threshold hit.
      send_k(8);
      check_value("resync2", 112'(sync_n), 112'd1);
      send_ilas(-1);
      for (int w = 0; w < 3; w++) send_word(32'h00000000, 4'h0, 4'h0, 1'b0);
      send_word(32'h7C000000, 4'h8, 4'h0, 1'b0);
      check_value("rs_pre_cnt", 112'(err_cnt), 112'd1);
      send_word(32'h00000000, 4'h0, 4'h1, 1'b1);
      check_value("rs_state", 112'(link_state), 112'd0);
      check_value("rs_no_err", 112'(link_err), 112'd0);
      check_value("rs_sync", 112'(sync_n), 112'd0);
      check_value("rs_valid", 112'(rx_valid), 112'd0);

      // Asynchronous rst_glb in the middle of ILAS.
      send_k(8);
      send_word(32'h0000001C, 4'h1, 4'h0, 1'b0);
      send_word(32'h00000000, 4'h0, 4'h0, 1'b0);
      check_value("pre_rst_state", 112'(link_state), 112'd1);
      #2;
      rst_glb = 1'b1;
      #1;
      check_value("arst_sync_n", 112'(sync_n), 112'd0);
      check_value("arst_state", 112'(link_state), 112'd0);
      check_value("arst_cfg", ilas_cfg, 112'd0);
      check_value("arst_frame", 112'(rx_frame), 112'd0);
      check_value("arst_errcnt", 112'(err_cnt), 112'd0);
      check_value("arst_cfgv", 112'(ilas_cfg_valid), 112'd0);
      check_value("arst_linkerr", 112'(link_err), 112'd0);
      @(negedge clk_user_bufg);
      rst_glb = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
